// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt controller (SR, Cause, EPC) beside the M stage.
// Optional CP0_EPC_BYPASS_EN forwards an in-flight mtc0 EPC straight onto EPCOut.
module cp0_unit #(
    parameter logic [5:0]  SR_IM_RESET = 6'h00,
    parameter logic [31:0] HANDLER_PC  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    output logic [31:0] DOut,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] HandlerPC,
    output logic        IntResp
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic        int_req;
    logic        exc_req;

    assign sr_val    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
    assign cause_val = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};

    assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;

    assign Req       = int_req | exc_req;
    assign IntResp   = int_req;
    assign HandlerPC = HANDLER_PC;

    always_comb begin
        DOut = 32'b0;
        case (A1)
            REG_SR:    DOut = sr_val;
            REG_CAUSE: DOut = cause_val;
            REG_EPC:   DOut = epc;
            default:   DOut = 32'b0;
        endcase
    end

`ifdef CP0_EPC_BYPASS_EN
    assign EPCOut = (WE && A2 == REG_EPC && !Req) ? DIn : epc;
`else
    assign EPCOut = epc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= SR_IM_RESET;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'b0;
            cause_exc <= 5'b0;
            epc       <= 32'b0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                // mtc0 and eret in this cycle belong to flushed instructions
                sr_exl    <= 1'b1;
                cause_bd  <= BDIn;
                cause_exc <= int_req ? 5'd0 : ExcCodeIn;
                epc       <= BDIn ? VPC - 32'd4 : VPC;
            end else begin
                if (WE && A2 == REG_SR) begin
                    sr_im  <= DIn[15:10];
                    sr_exl <= DIn[1];
                    sr_ie  <= DIn[0];
                end
                if (WE && A2 == REG_EPC) begin
                    epc <= DIn;
                end
                if (EXLClr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: expected register values are queued with
// each stimulus step and compared against DOut/EPCOut after the clock edge.
`timescale 1ns/1ps
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [31:0] DOut;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] HandlerPC;
    logic        IntResp;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_epcout;
        logic [4:0]  addr;
        logic [31:0] val;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    cp0_unit dut (
        .clk(clk), .reset(reset), .A1(A1), .DOut(DOut),
        .A2(A2), .DIn(DIn), .WE(WE), .VPC(VPC), .BDIn(BDIn),
        .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
        .Req(Req), .EPCOut(EPCOut), .HandlerPC(HandlerPC),
        .IntResp(IntResp)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input logic e,
                        input logic [4:0] a, input logic [31:0] v);
        exp_t x;
        x.is_epcout = e;
        x.addr = a;
        x.val = v;
        exp_q.push_back(x);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        exp_t  x;
        string t;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            t = tag_q.pop_front();
            A1 = x.addr;
            #1;
            if (x.is_epcout) check(t, EPCOut, x.val);
            else             check(t, DOut, x.val);
        end
    endtask

    // one cycle: drive at negedge, check Req/IntResp, clock, then drain
    task automatic step(input string tag, input logic we,
                        input logic [4:0] a2, input logic [31:0] din,
                        input logic [5:0] hw, input logic [4:0] exc,
                        input logic bd, input logic [31:0] vpc,
                        input logic clr, input logic req_x,
                        input logic int_x);
        @(negedge clk);
        WE = we; A2 = a2; DIn = din; HWInt = hw;
        ExcCodeIn = exc; BDIn = bd; VPC = vpc; EXLClr = clr;
        #1;
        check({tag, ".req"}, {31'b0, Req}, {31'b0, req_x});
        check({tag, ".int"}, {31'b0, IntResp}, {31'b0, int_x});
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'b0; WE = 1'b0;
        VPC = 32'b0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0;
        EXLClr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.req", {31'b0, Req}, 32'd0);
        check("rst.int", {31'b0, IntResp}, 32'd0);
        check("rst.epcout", EPCOut, 32'd0);
        check("handler", HandlerPC, 32'h0000_4180);
        push("rst.sr", 0, 5'd12, 32'h0);
        push("rst.cause", 0, 5'd13, 32'h0);
        push("rst.epc", 0, 5'd14, 32'h0);
        push("rst.unmapped", 0, 5'd5, 32'h0);
        drain();

        push("t1.sr", 0, 5'd12, 32'h0000_0401);
        step("t1.mtc0", 1, 5'd12, 32'h0000_0401, 6'd0, 5'd0, 0, 32'h0, 0, 0, 0);
        push("t1.sr", 0, 5'd12, 32'h0000_0403);
        push("t1.cause", 0, 5'd13, 32'h0000_0400);
        push("t1.epc", 0, 5'd14, 32'h0000_3008);
        step("t1.irq", 0, 5'd0, 32'h0, 6'b000001, 5'd0, 0, 32'h3008, 0, 1, 1);

        push("t2.sr", 0, 5'd12, 32'h0000_0401);
        push("t2.cause", 0, 5'd13, 32'h0);
        step("t2.eret", 0, 5'd0, 32'h0, 6'd0, 5'd0, 0, 32'h0, 1, 0, 0);
        push("t2.cause", 0, 5'd13, 32'h8000_0010);
        push("t2.epc", 0, 5'd14, 32'h0000_300C);
        push("t2.sr", 0, 5'd12, 32'h0000_0403);
        step("t2.exc", 0, 5'd0, 32'h0, 6'd0, 5'd4, 1, 32'h3010, 0, 1, 0);

        push("t3.sr", 0, 5'd12, 32'h0000_1401);
        step("t3.exlwin", 1, 5'd12, 32'h0000_1403, 6'd0, 5'd0, 0, 32'h0, 1, 0, 0);
        push("t3.cause", 0, 5'd13, 32'h0000_1000);
        push("t3.epc", 0, 5'd14, 32'h0000_3020);
        push("t3.sr", 0, 5'd12, 32'h0000_1403);
        step("t3.prio", 0, 5'd0, 32'h0, 6'b000100, 5'd10, 0, 32'h3020, 0, 1, 1);

        push("t4.sr", 0, 5'd12, 32'h0000_1403);
        push("t4.epc", 0, 5'd14, 32'h0000_3020);
        step("t4.masked", 0, 5'd0, 32'h0, 6'b000100, 5'd12, 0, 32'h3024, 0, 0, 0);
        push("t4.sr", 0, 5'd12, 32'h0000_1401);
        step("t4.eret", 0, 5'd0, 32'h0, 6'b000100, 5'd0, 0, 32'h0, 1, 0, 0);
        push("t5.epc", 0, 5'd14, 32'h0000_3030);
        push("t5.sr", 0, 5'd12, 32'h0000_1403);
        step("t5.drop", 1, 5'd14, 32'h3100, 6'b000100, 5'd0, 0, 32'h3030, 1, 1, 1);
        push("t5.cause", 0, 5'd13, 32'h0000_1000);
        step("t5.cause_ro", 1, 5'd13, 32'hFFFF_FFFF, 6'b000100, 5'd0, 0, 32'h0, 0, 0, 0);

        push("t6.sr", 0, 5'd12, 32'h0000_1401);
        step("t6.eret", 0, 5'd0, 32'h0, 6'd0, 5'd0, 0, 32'h0, 1, 0, 0);
        push("t6.epc", 0, 5'd14, 32'hFFFF_FFFC);
        push("t6.cause", 0, 5'd13, 32'h8000_0004);
        step("t6.wrap", 0, 5'd0, 32'h0, 6'd0, 5'd1, 1, 32'h0, 0, 1, 0);

        @(negedge clk);
        WE = 1; A2 = 5'd14; DIn = 32'h0000_3200; HWInt = 6'd0;
        ExcCodeIn = 5'd0; BDIn = 0; VPC = 32'h0; EXLClr = 0;
        #1;
`ifdef CP0_EPC_BYPASS_EN
        check("t7.bypass", EPCOut, 32'h0000_3200);
`else
        check("t7.nobypass", EPCOut, 32'hFFFF_FFFC);
`endif
        push("t7.epc", 0, 5'd14, 32'h0000_3200);
        push("t7.epcout", 1, 5'd0, 32'h0000_3200);
        @(posedge clk);
        #1;
        drain();

        @(negedge clk);
        reset = 1; WE = 0; HWInt = 6'b000100;
        @(posedge clk);
        #1;
        push("t8.sr", 0, 5'd12, 32'h0);
        push("t8.cause", 0, 5'd13, 32'h0);
        push("t8.epc", 0, 5'd14, 32'h0);
        drain();
        @(negedge clk);
        reset = 0;
        push("t8.cause", 0, 5'd13, 32'h0000_1000);
        push("t8.sr", 0, 5'd12, 32'h0);
        step("t8.noie", 0, 5'd0, 32'h0, 6'b000100, 5'd0, 0, 32'h3040, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
